// File: rtl/seq_multiplier_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Purpose  : Funct codes and FSM state encoding for seq_multiplier_ext.
// Revision : 1.0
// ============================================================================
package mul_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_OUT   = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_mul_funct(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_multiplier_ext_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier_ext_if
// Purpose  : Request/response bundle between the datapath and the multiplier.
// Revision : 1.0
// ============================================================================
interface seq_multiplier_ext_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  logic [5:0]           Signal;
  logic [WIDTH-1:0]     dataA;
  logic [WIDTH-1:0]     dataB;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   dataOut;

  modport master (
    output start, Signal, dataA, dataB,
    input  busy, done, dataOut
  );

  modport slave (
    input  start, Signal, dataA, dataB,
    output busy, done, dataOut
  );

endinterface
`default_nettype wire

// File: rtl/seq_multiplier_ext_sign_fix.sv
`default_nettype none
// ============================================================================
// Module   : mul_sign_fix
// Purpose  : Operand magnitudes for signed MULT and conditional result negate.
// Revision : 1.0
// ============================================================================
module mul_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic                 is_signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [WIDTH-1:0]     abs_a_o,
  output logic [WIDTH-1:0]     abs_b_o,
  output logic                 neg_o,
  input  logic                 neg_i,
  input  logic [2*WIDTH-1:0]   prod_i,
  output logic [2*WIDTH-1:0]   prod_o
);

  // MIN_INT negates to itself, which is its correct unsigned magnitude
  assign abs_a_o = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign abs_b_o = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  assign neg_o   = is_signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);

  assign prod_o  = neg_i ? -prod_i : prod_i;

endmodule
`default_nettype wire

// File: rtl/seq_multiplier_ext.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier_ext
// Purpose  : Iterative shift-add MULT/MULTU with HI/LO readout, one bit/cycle.
// Revision : 1.0
// ============================================================================
module seq_multiplier_ext
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  seq_multiplier_ext_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q,   acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q,   neg_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [WIDTH-1:0]     hi_q,    hi_d;
  logic [WIDTH-1:0]     lo_q,    lo_d;
  logic [2*WIDTH-1:0]   dout_q,  dout_d;

  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic                 w_neg;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_shifted;
  logic [2*WIDTH-1:0]   w_prod_fixed;

  mul_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_signed_i (bus.Signal == FUNCT_MULT),
    .a_i         (bus.dataA),
    .b_i         (bus.dataB),
    .abs_a_o     (w_abs_a),
    .abs_b_o     (w_abs_b),
    .neg_o       (w_neg),
    .neg_i       (neg_q),
    .prod_i      (w_shifted),
    .prod_o      (w_prod_fixed)
  );

  // Upper half plus carry, then the whole accumulator shifts right by one
  assign w_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign w_shifted = {w_sum, acc_q[WIDTH-1:1]};

  assign bus.busy    = (state_q == BUSY);
  assign bus.done    = (state_q == DONE);
  assign bus.dataOut = dout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dout_d  = dout_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          if (is_mul_funct(bus.Signal)) begin
            state_d = BUSY;
            mcand_d = w_abs_a;
            acc_d   = {{WIDTH{1'b0}}, w_abs_b};
            neg_d   = w_neg;
            cnt_d   = '0;
          end else begin
            case (bus.Signal)
              FUNCT_MFHI: dout_d = {{WIDTH{1'b0}}, hi_q};
              FUNCT_MFLO: dout_d = {{WIDTH{1'b0}}, lo_q};
              FUNCT_OUT:  dout_d = {hi_q, lo_q};
              default:    dout_d = dout_q;
            endcase
          end
        end
      end

      BUSY: begin
        acc_d = w_shifted;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d      = DONE;
          {hi_d, lo_d} = w_prod_fixed;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire
